blake2b_msg_feeder: RTL and testbench

Front end for the BLAKE2b compression core. It accepts a little-endian message as a stream of 64-bit words and assembles 128-byte blocks with zero padding. It tracks the byte offset t and the final flag, drives the core's request interface, and holds h and m stable until the core answers. After the final block it presents the 512-bit chaining value as the digest. Unkeyed hashing only.

---
 rtl/blake2b_pkg.sv | 33 +++
 rtl/blake2b_msg_buf.sv | 40 ++++
 rtl/blake2b_msg_feeder.sv | 123 ++++++++++++
 tb/tb_blake2b_msg_feeder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2b_pkg.sv
// Shared constants, state encoding and initial chaining value for the BLAKE2b message feeder.
package blake2b_pkg;

  localparam int unsigned W           = 64;
  localparam int unsigned BLOCK_WORDS = 16;

  // Parameter-block word 0 for an unkeyed hash: fanout = 1, depth = 1, key length = 0.
  localparam logic [63:0] PARAM_BLOCK = 64'h0000_0000_0101_0000;

  // IV[i] lives at IV[i] (word 0 is the least significant).
  localparam logic [7:0][63:0] IV = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };

  typedef enum logic [1:0] {
    ST_INIT,
    ST_FILL,
    ST_CMP,
    ST_DONE
  } state_e;

  // Initial chaining value for an nn-byte digest.
  function automatic logic [511:0] init_h(input logic [7:0] nn);
    logic [511:0] h;
    h        = IV;
    h[63:0]  = IV[0] ^ PARAM_BLOCK ^ {56'b0, nn};
    return h;
  endfunction

endpackage

// File: rtl/blake2b_msg_buf.sv
// 16 x 64-bit message block register with word-indexed writes and tail byte masking.
module blake2b_msg_buf
  import blake2b_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr_i,
  input  logic                        we_i,
  input  logic [3:0]                  idx_i,
  input  logic [W-1:0]                data_i,
  input  logic                        last_i,
  input  logic [3:0]                  nbytes_i,
  output logic [BLOCK_WORDS*W-1:0]    m_o
);

  logic [BLOCK_WORDS-1:0][W-1:0] m_q, m_d;
  logic [W-1:0]                  masked;

  // Zero bytes beyond the valid count of the last word, then apply clear or write.
  always_comb begin
    masked = data_i;
    if (last_i) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (b >= {28'b0, nbytes_i}) masked[8*b +: 8] = '0;
      end
    end
    m_d = m_q;
    if (clr_i)     m_d = '0;
    else if (we_i) m_d[idx_i] = masked;
  end

  // Block storage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) m_q <= '0;
    else       m_q <= m_d;
  end

  assign m_o = m_q;

endmodule

// File: rtl/blake2b_msg_feeder.sv
// Assembles padded 128-byte blocks from a 64-bit word stream, drives the BLAKE2b
// compression core handshake and presents the final chaining value as the digest.
module blake2b_msg_feeder #(
  parameter int unsigned W  = 64,
  parameter int unsigned NN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_valid_i,
  output logic            data_ready_o,
  input  logic [W-1:0]    data_i,
  input  logic            data_last_i,
  input  logic [3:0]      data_bytes_i,
  output logic            cmp_valid_o,
  output logic [8*W-1:0]  cmp_h_o,
  output logic [16*W-1:0] cmp_m_o,
  output logic [127:0]    cmp_t_o,
  output logic            cmp_f_o,
  input  logic [8*W-1:0]  cmp_h_i,
  input  logic            cmp_valid_i,
  output logic            digest_valid_o,
  input  logic            digest_ready_i,
  output logic [8*W-1:0]  digest_o
);
  import blake2b_pkg::*;

  state_e         state_q, state_d;
  logic [511:0]   h_q, h_d;
  logic [127:0]   t_q, t_d;
  logic           f_q, f_d;
  logic [3:0]     idx_q, idx_d;
  logic           cmp_valid_q, cmp_valid_d;
  logic           buf_clr, buf_we;

  blake2b_msg_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (buf_clr),
    .we_i     (buf_we),
    .idx_i    (idx_q),
    .data_i   (data_i),
    .last_i   (data_last_i),
    .nbytes_i (data_bytes_i),
    .m_o      (cmp_m_o)
  );

  // Next-state, counter and buffer-control logic.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    t_d          = t_q;
    f_d          = f_q;
    idx_d        = idx_q;
    cmp_valid_d  = 1'b0;
    buf_clr      = 1'b0;
    buf_we       = 1'b0;
    data_ready_o = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        h_d     = init_h(NN[7:0]);
        buf_clr = 1'b1;
        idx_d   = '0;
        t_d     = '0;
        f_d     = 1'b0;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          buf_we = 1'b1;
          t_d    = t_q + (data_last_i ? {124'b0, data_bytes_i} : 128'd8);
          // A full block without last launches with f = 0; more data must follow.
          if (data_last_i || idx_q == 4'd15) begin
            f_d         = data_last_i;
            cmp_valid_d = 1'b1;
            state_d     = ST_CMP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_CMP: begin
        if (cmp_valid_i) begin
          h_d     = cmp_h_i;
          buf_clr = 1'b1;
          idx_d   = '0;
          state_d = f_q ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        if (digest_ready_i) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, chaining value, offset and launch pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      h_q         <= init_h(NN[7:0]);
      t_q         <= '0;
      f_q         <= 1'b0;
      idx_q       <= '0;
      cmp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      t_q         <= t_d;
      f_q         <= f_d;
      idx_q       <= idx_d;
      cmp_valid_q <= cmp_valid_d;
    end
  end

  assign cmp_valid_o    = cmp_valid_q;
  assign cmp_h_o        = h_q;
  assign cmp_t_o        = t_q;
  assign cmp_f_o        = f_q;
  assign digest_valid_o = (state_q == ST_DONE);
  assign digest_o       = digest_valid_o ? h_q : '0;

endmodule

// File: tb/tb_blake2b_msg_feeder.sv
// Directed bench for blake2b_msg_feeder; the bench plays the compression core.
module tb_blake2b_msg_feeder;

  localparam logic [511:0] IVS = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };
  localparam logic [511:0] H_INIT = {IVS[511:64], 64'h6a09e667f2bdc948};
  localparam logic [63:0] SIGMA [10] = '{
    64'h0123456789abcdef, 64'hea489fd61c02b753, 64'hb8c052fdae367194,
    64'h7931dcbe265a40f8, 64'h905724afe1bc683d, 64'h2c6a0b834d75fe19,
    64'hc51fed4a0763928b, 64'hdb7ec13950f4862a, 64'h6fe9b308c2d714a5,
    64'ha2847615fb9e3cd0
  };

  logic          clk = 1'b0, reset = 1'b1;
  logic          data_valid_i = 1'b0, data_last_i = 1'b0;
  logic [63:0]   data_i = '0;
  logic [3:0]    data_bytes_i = '0;
  logic          cmp_valid_i = 1'b0, digest_ready_i = 1'b0;
  logic [511:0]  cmp_h_i = '0;
  logic          data_ready_o, cmp_valid_o, cmp_f_o, digest_valid_o;
  logic [511:0]  cmp_h_o, digest_o;
  logic [1023:0] cmp_m_o;
  logic [127:0]  cmp_t_o;

  int n_assert = 0, n_fail = 0, n_cmp = 0;

  blake2b_msg_feeder #(.W(64), .NN(64)) dut (
    .clk(clk), .reset(reset),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .data_last_i(data_last_i), .data_bytes_i(data_bytes_i),
    .cmp_valid_o(cmp_valid_o), .cmp_h_o(cmp_h_o), .cmp_m_o(cmp_m_o),
    .cmp_t_o(cmp_t_o), .cmp_f_o(cmp_f_o), .cmp_h_i(cmp_h_i), .cmp_valid_i(cmp_valid_i),
    .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i), .digest_o(digest_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmp_valid_o === 1'b1) n_cmp++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference BLAKE2b compression function F.
  function automatic logic [511:0] compress(input logic [511:0] h, input logic [1023:0] m,
                                            input logic [127:0] t, input logic f);
    logic [63:0] v [16];
    logic [63:0] mw [16];
    logic [63:0] sig, x, y;
    logic [511:0] r;
    int a, b, c, d, i;
    for (int k = 0; k < 8; k++) begin
      v[k]   = h[64*k +: 64];
      v[k+8] = IVS[64*k +: 64];
    end
    for (int k = 0; k < 16; k++) mw[k] = m[64*k +: 64];
    v[12] = v[12] ^ t[63:0];
    v[13] = v[13] ^ t[127:64];
    if (f) v[14] = ~v[14];
    for (int rnd = 0; rnd < 12; rnd++) begin
      sig = SIGMA[rnd % 10];
      for (int k = 0; k < 8; k++) begin
        if (k < 4) begin
          a = k; b = 4 + k; c = 8 + k; d = 12 + k;
        end else begin
          i = k - 4;
          a = i; b = 4 + ((i + 1) % 4); c = 8 + ((i + 2) % 4); d = 12 + ((i + 3) % 4);
        end
        x = mw[sig[63-8*k -: 4]];
        y = mw[sig[59-8*k -: 4]];
        v[a] = v[a] + v[b] + x;  v[d] = ror(v[d] ^ v[a], 32);
        v[c] = v[c] + v[d];      v[b] = ror(v[b] ^ v[c], 24);
        v[a] = v[a] + v[b] + y;  v[d] = ror(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];      v[b] = ror(v[b] ^ v[c], 63);
      end
    end
    for (int k = 0; k < 8; k++) r[64*k +: 64] = h[64*k +: 64] ^ v[k] ^ v[k+8];
    return r;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb,
                           output bit ok);
    int n;
    n = 0;
    data_valid_i = 1'b1; data_i = d; data_last_i = l; data_bytes_i = nb;
    while (data_ready_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    ok = (data_ready_o === 1'b1);
    @(negedge clk);
    data_valid_i = 1'b0; data_last_i = 1'b0; data_bytes_i = '0; data_i = '0;
  endtask

  task automatic wait_cmp(output bit ok);
    int n;
    n = 0;
    while (cmp_valid_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    ok = (cmp_valid_o === 1'b1);
  endtask

  task automatic wait_digest(output bit ok);
    int n;
    n = 0;
    while (digest_valid_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    ok = (digest_valid_o === 1'b1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (data_ready_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic core_respond(input int delay);
    repeat (delay) @(negedge clk);
    cmp_h_i = compress(cmp_h_o, cmp_m_o, cmp_t_o, cmp_f_o);
    cmp_valid_i = 1'b1;
    @(negedge clk);
    cmp_valid_i = 1'b0; cmp_h_i = '0;
  endtask

  task automatic release_digest();
    digest_ready_i = 1'b1;
    @(negedge clk);
    digest_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({cmp_valid_o, data_ready_o, digest_valid_o, cmp_f_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
                         {cmp_valid_o, data_ready_o, digest_valid_o, cmp_f_o});
    end
    n_assert++;
    if (cmp_t_o !== '0 || cmp_m_o !== '0 || digest_o !== '0) begin
      n_fail++; $display("FAIL reset_data: t=%0d m0=%h d0=%h expected zeros",
                         cmp_t_o, cmp_m_o[63:0], digest_o[63:0]);
    end
    n_assert++;
    if (cmp_h_o !== H_INIT) begin
      n_fail++; $display("FAIL reset_h: got h0=%h expected %h", cmp_h_o[63:0], H_INIT[63:0]);
    end
    reset = 1'b0;
    #1;
    n_assert++;
    if (data_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL init_ready: got %b expected 0", data_ready_o);
    end
    @(negedge clk);
    n_assert++;
    if (data_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL fill_ready: got %b expected 1", data_ready_o);
    end
  endtask

  task automatic test_abc();
    bit ok, bad;
    logic [1023:0] exp_m;
    logic [511:0] snap;
    n_cmp = 0;
    exp_m = '0; exp_m[63:0] = 64'h636261;
    send_word(64'hdeadbeef_ff636261, 1'b1, 4'd3, ok);
    wait_cmp(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL abc_launch: got no cmp_valid_o expected pulse"); end
    n_assert++;
    if (cmp_t_o !== 128'd3 || cmp_f_o !== 1'b1) begin
      n_fail++; $display("FAIL abc_tf: got t=%0d f=%b expected t=3 f=1", cmp_t_o, cmp_f_o);
    end
    n_assert++;
    if (cmp_m_o !== exp_m) begin
      n_fail++; $display("FAIL abc_m: got m0=%h m1=%h expected m0=%h rest 0",
                         cmp_m_o[63:0], cmp_m_o[127:64], exp_m[63:0]);
    end
    core_respond(3);
    wait_digest(ok);
    n_assert++;
    if (!ok || digest_o[127:0] !== {64'he9f6129fb697276a, 64'h0d4d1c983fa580ba}) begin
      n_fail++; $display("FAIL abc_digest: got %h expected e9f6129fb697276a0d4d1c983fa580ba",
                         digest_o[127:0]);
    end
    snap = digest_o; bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (digest_valid_o !== 1'b1 || digest_o !== snap) bad = 1;
    end
    n_assert++;
    if (bad) begin n_fail++; $display("FAIL digest_hold: got change while held expected stable"); end
    n_assert++;
    if (n_cmp !== 1) begin n_fail++; $display("FAIL abc_ncmp: got %0d expected 1", n_cmp); end
    release_digest();
    n_assert++;
    if (digest_valid_o !== 1'b0 || digest_o !== '0) begin
      n_fail++; $display("FAIL digest_release: got valid=%b expected 0", digest_valid_o);
    end
  endtask

  task automatic test_empty();
    bit ok;
    send_word(64'hffff_ffff_ffff_ffff, 1'b1, 4'd0, ok);
    wait_cmp(ok);
    n_assert++;
    if (!ok || cmp_t_o !== '0 || cmp_f_o !== 1'b1 || cmp_m_o !== '0) begin
      n_fail++; $display("FAIL empty_block: got t=%0d f=%b m0=%h expected t=0 f=1 m=0",
                         cmp_t_o, cmp_f_o, cmp_m_o[63:0]);
    end
    n_assert++;
    if (cmp_h_o !== H_INIT) begin
      n_fail++; $display("FAIL empty_h: got h0=%h expected %h", cmp_h_o[63:0], H_INIT[63:0]);
    end
    core_respond(0);
    wait_digest(ok);
    n_assert++;
    if (!ok || digest_o[127:0] !== {64'h72d2522585fdc6c6, 64'h03590142f7026a78}) begin
      n_fail++; $display("FAIL empty_digest: got %h expected 72d2522585fdc6c603590142f7026a78",
                         digest_o[127:0]);
    end
    release_digest();
  endtask

  task automatic test_128();
    bit ok, all_ok, early;
    logic [1023:0] exp_m;
    logic [63:0] w;
    n_cmp = 0; all_ok = 1; early = 0;
    for (int i = 0; i < 16; i++) begin
      w = 64'h0706050403020100 + 64'(i) * 64'h0808080808080808;
      exp_m[64*i +: 64] = w;
      send_word(w, (i == 15), 4'd8, ok);
      all_ok &= ok;
      if (i < 15 && cmp_valid_o !== 1'b0) early = 1;
    end
    n_assert++;
    if (!all_ok || early) begin
      n_fail++; $display("FAIL b128_stream: got accepted=%b early_launch=%b expected 1 0", all_ok, early);
    end
    wait_cmp(ok);
    n_assert++;
    if (!ok || cmp_t_o !== 128'd128 || cmp_f_o !== 1'b1 || cmp_m_o !== exp_m) begin
      n_fail++; $display("FAIL b128_block: got t=%0d f=%b m15=%h expected t=128 f=1 m15=%h",
                         cmp_t_o, cmp_f_o, cmp_m_o[1023:960], exp_m[1023:960]);
    end
    core_respond(1);
    wait_digest(ok);
    n_assert++;
    if (!ok || digest_o !== compress(H_INIT, exp_m, 128'd128, 1'b1)) begin
      n_fail++; $display("FAIL b128_digest: got d0=%h expected %h", digest_o[63:0],
                         compress(H_INIT, exp_m, 128'd128, 1'b1) & 512'hffff_ffff_ffff_ffff);
    end
    n_assert++;
    if (n_cmp !== 1) begin n_fail++; $display("FAIL b128_ncmp: got %0d expected 1", n_cmp); end
    release_digest();
  endtask

  task automatic test_129_stall();
    bit ok, all_ok, bad;
    logic [1023:0] exp_m1, exp_m2;
    logic [511:0] h1, exp_d;
    logic [1664:0] snap;
    logic [63:0] w;
    wait_ready();
    cmp_h_i = '1; cmp_valid_i = 1'b1;
    @(negedge clk);
    cmp_valid_i = 1'b0; cmp_h_i = '0;
    n_assert++;
    if (data_ready_o !== 1'b1 || cmp_h_o !== H_INIT || cmp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL spurious_cmp: got ready=%b h0=%h expected ready=1 h0=%h",
                         data_ready_o, cmp_h_o[63:0], H_INIT[63:0]);
    end
    all_ok = 1;
    for (int i = 0; i < 16; i++) begin
      w = 64'hf0e0d0c0b0a09080 ^ (64'(i) * 64'h0101010101010101);
      exp_m1[64*i +: 64] = w;
      send_word(w, 1'b0, 4'd8, ok);
      all_ok &= ok;
    end
    wait_cmp(ok);
    n_assert++;
    if (!all_ok || !ok || cmp_t_o !== 128'd128 || cmp_f_o !== 1'b0 || cmp_m_o !== exp_m1) begin
      n_fail++; $display("FAIL b129_first: got t=%0d f=%b expected t=128 f=0", cmp_t_o, cmp_f_o);
    end
    snap = {cmp_h_o, cmp_m_o, cmp_t_o, cmp_f_o};
    data_valid_i = 1'b1; data_i = 64'h1122334455667788; data_last_i = 1'b1; data_bytes_i = 4'd1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (data_ready_o !== 1'b0 || cmp_valid_o !== 1'b0 ||
          {cmp_h_o, cmp_m_o, cmp_t_o, cmp_f_o} !== snap) bad = 1;
    end
    data_valid_i = 1'b0; data_last_i = 1'b0; data_bytes_i = '0;
    n_assert++;
    if (bad) begin n_fail++; $display("FAIL stall_hold: got change during stall expected stable"); end
    h1 = compress(H_INIT, exp_m1, 128'd128, 1'b0);
    core_respond(0);
    exp_m2 = '0; exp_m2[63:0] = 64'h88;
    send_word(64'h1122334455667788, 1'b1, 4'd1, ok);
    wait_cmp(ok);
    n_assert++;
    if (!ok || cmp_t_o !== 128'd129 || cmp_f_o !== 1'b1 || cmp_m_o !== exp_m2) begin
      n_fail++; $display("FAIL b129_second: got t=%0d f=%b m0=%h expected t=129 f=1 m0=88",
                         cmp_t_o, cmp_f_o, cmp_m_o[63:0]);
    end
    n_assert++;
    if (cmp_h_o !== h1) begin
      n_fail++; $display("FAIL b129_chain: got h0=%h expected %h", cmp_h_o[63:0], h1[63:0]);
    end
    exp_d = compress(h1, exp_m2, 128'd129, 1'b1);
    core_respond(2);
    wait_digest(ok);
    n_assert++;
    if (!ok || digest_o !== exp_d) begin
      n_fail++; $display("FAIL b129_digest: got d0=%h expected %h", digest_o[63:0], exp_d[63:0]);
    end
    release_digest();
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_word(64'h636261, 1'b1, 4'd3, ok);
    wait_cmp(ok);
    reset = 1'b1;
    #1;
    n_assert++;
    if (!ok || {cmp_valid_o, data_ready_o, digest_valid_o, cmp_f_o} !== 4'b0 ||
        cmp_t_o !== '0 || cmp_m_o !== '0 || cmp_h_o !== H_INIT) begin
      n_fail++; $display("FAIL reset_mid: got v=%b t=%0d f=%b m0=%h expected reset values",
                         cmp_valid_o, cmp_t_o, cmp_f_o, cmp_m_o[63:0]);
    end
    @(negedge clk);
    cmp_h_i = '1; cmp_valid_i = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    cmp_valid_i = 1'b0; cmp_h_i = '0;
    n_assert++;
    if (data_ready_o !== 1'b1 || cmp_h_o !== H_INIT || cmp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL late_cmp: got ready=%b h0=%h expected ready=1 h0=%h",
                         data_ready_o, cmp_h_o[63:0], H_INIT[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_128();
    test_129_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
